// File: rtl/reg_dump_reader.sv
// Walks register numbers FIRST_REG..LAST_REG over a register-file read port.
// Each captured (number, data) pair goes to a debug sink through a valid/ready handshake.
module reg_dump_reader #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31,
    parameter int WIDTH     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [4:0]       RN,
    input  logic [WIDTH-1:0] RD,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_num,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
);

    generate
        if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
            $error("reg_dump_reader: need 0 <= FIRST_REG <= LAST_REG <= 31");
        end
    endgenerate

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_reg;
    logic [4:0] idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= FIRST_IDX;
            RN        <= 5'd0;
            out_valid <= 1'b0;
            out_num   <= 5'd0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            // abort is the only path that may withdraw a pending beat
            if (abort && state_reg != IDLE) begin
                state_reg <= IDLE;
                idx_reg   <= FIRST_IDX;
                RN        <= 5'd0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start && !abort) begin
                            state_reg <= ADDR;
                            idx_reg   <= FIRST_IDX;
                            RN        <= FIRST_IDX;
                            busy      <= 1'b1;
                        end
                    end
                    ADDR: begin
                        // RN has been stable all cycle, so RD is settled here
                        out_data  <= RD;
                        out_num   <= idx_reg;
                        out_valid <= 1'b1;
                        state_reg <= SEND;
                    end
                    SEND: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (idx_reg == LAST_IDX) begin
                                state_reg <= DONE;
                                done      <= 1'b1;
                            end else begin
                                idx_reg   <= idx_reg + 5'd1;
                                RN        <= idx_reg + 5'd1;
                                state_reg <= ADDR;
                            end
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                        idx_reg   <= FIRST_IDX;
                        RN        <= 5'd0;
                        busy      <= 1'b0;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: a full-range instance driven by hand sequences and
// a 0..2 instance driven by a cycle-by-cycle vector table.
module tb_reg_dump_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] rf [32];

    logic        start_a, abort_a, ready_a, valid_a, busy_a, done_a;
    logic [4:0]  rn_a, num_a;
    logic [31:0] rd_a, data_a;

    logic        start_b, abort_b, ready_b, valid_b, busy_b, done_b;
    logic [4:0]  rn_b, num_b;
    logic [31:0] rd_b, data_b;

    assign rd_a = (rn_a == 5'd0) ? 32'd0 : rf[rn_a];
    assign rd_b = (rn_b == 5'd0) ? 32'd0 : rf[rn_b];

    reg_dump_reader #(.FIRST_REG(1), .LAST_REG(31), .WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .RN(rn_a), .RD(rd_a), .out_valid(valid_a), .out_ready(ready_a),
        .out_num(num_a), .out_data(data_a), .busy(busy_a), .done(done_a)
    );

    reg_dump_reader #(.FIRST_REG(0), .LAST_REG(2), .WIDTH(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .RN(rn_b), .RD(rd_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_num(num_b), .out_data(data_b), .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        s, a, r;
        logic [4:0]  rn;
        logic        v;
        logic [4:0]  n;
        logic [31:0] d;
        logic        b, dn;
    } vec_t;
    vec_t tbl [22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input int s, input int a, input int r, input int rn,
                        input int v, input int n, input int d, input int b, input int dn);
        tbl[i].s  = 1'(s);
        tbl[i].a  = 1'(a);
        tbl[i].r  = 1'(r);
        tbl[i].rn = 5'(rn);
        tbl[i].v  = 1'(v);
        tbl[i].n  = 5'(n);
        tbl[i].d  = 32'(d);
        tbl[i].b  = 1'(b);
        tbl[i].dn = 1'(dn);
    endtask

    // Bounded wait for beat n on the full-range instance
    task automatic wait_beat(input int n);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (valid_a && num_a == 5'(n)) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk($sformatf("wait r%0d", n), {63'd0, ok}, 64'd1);
    endtask

    function automatic logic [31:0] exp_b(input int n);
        return (n == 9) ? 32'hDEAD : 32'(100 + n);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  exp_n, stall, first7, last7, first8, gap_err, early_done;
        bit  wrote, prev_v, got_done;

        for (int i = 0; i < 32; i++) rf[i] = 32'(100 + i);
        rf[0] = 32'd0;
        rst_n = 1'b0;
        {start_a, abort_a, ready_a, start_b, abort_b, ready_b} = '0;
        step();
        step();
        chk("reset a", {19'd0, rn_a, valid_a, num_a, data_a, busy_a, done_a}, 64'd0);
        chk("reset b", {19'd0, rn_b, valid_b, num_b, data_b, busy_b, done_b}, 64'd0);
        rst_n = 1'b1;
        step();

        // ---- vector table on FIRST_REG=0, LAST_REG=2 ----
        //      i   s  a  r  rn v  n  d    b  dn
        setv( 0, 1, 0, 1, 0, 0, 0, 0,   1, 0);
        setv( 1, 0, 0, 1, 0, 1, 0, 0,   1, 0);
        setv( 2, 0, 0, 1, 1, 0, 0, 0,   1, 0);
        setv( 3, 0, 0, 1, 1, 1, 1, 101, 1, 0);
        setv( 4, 0, 0, 1, 2, 0, 1, 101, 1, 0);
        setv( 5, 0, 0, 1, 2, 1, 2, 102, 1, 0);
        setv( 6, 0, 0, 1, 2, 0, 2, 102, 1, 1);
        setv( 7, 0, 0, 1, 0, 0, 2, 102, 0, 0);
        setv( 8, 1, 1, 1, 0, 0, 2, 102, 0, 0);
        setv( 9, 0, 1, 1, 0, 0, 2, 102, 0, 0);
        setv(10, 1, 0, 0, 0, 0, 2, 102, 1, 0);
        setv(11, 0, 0, 0, 0, 1, 0, 0,   1, 0);
        setv(12, 0, 0, 0, 0, 1, 0, 0,   1, 0);
        setv(13, 0, 1, 0, 0, 0, 0, 0,   0, 0);
        setv(14, 1, 0, 1, 0, 0, 0, 0,   1, 0);
        setv(15, 0, 0, 1, 0, 1, 0, 0,   1, 0);
        setv(16, 1, 0, 1, 1, 0, 0, 0,   1, 0);
        setv(17, 0, 0, 1, 1, 1, 1, 101, 1, 0);
        setv(18, 0, 0, 1, 2, 0, 1, 101, 1, 0);
        setv(19, 0, 0, 1, 2, 1, 2, 102, 1, 0);
        setv(20, 0, 0, 1, 2, 0, 2, 102, 1, 1);
        setv(21, 0, 0, 1, 0, 0, 2, 102, 0, 0);
        for (int i = 0; i < 22; i++) begin
            start_b = tbl[i].s;
            abort_b = tbl[i].a;
            ready_b = tbl[i].r;
            step();
            chk($sformatf("vec%0d", i),
                {19'd0, rn_b, valid_b, num_b, data_b, busy_b, done_b},
                {19'd0, tbl[i].rn, tbl[i].v, tbl[i].n, tbl[i].d, tbl[i].b, tbl[i].dn});
        end
        {start_b, abort_b, ready_b} = '0;

        // ---- full dump, ready tied high ----
        start_a = 1'b1;
        ready_a = 1'b1;
        step();
        start_a = 1'b0;
        gap_err = 0;
        early_done = 0;
        for (int c = 1; c <= 62; c++) begin
            step();
            if (c % 2 == 1)
                chk($sformatf("dumpA r%0d", (c + 1) / 2), {26'd0, valid_a, num_a, data_a},
                    {26'd0, 1'b1, 5'((c + 1) / 2), 32'(100 + (c + 1) / 2)});
            else if (c < 62 && valid_a)
                gap_err++;
            if (c < 62 && done_a) early_done++;
        end
        chk("dumpA done", {61'd0, done_a, busy_a, valid_a}, 64'b110);
        chk("dumpA gaps", 64'(gap_err), 64'd0);
        chk("dumpA early done", 64'(early_done), 64'd0);
        step();
        chk("dumpA idle", {57'd0, done_a, busy_a, rn_a}, 64'd0);

        // ---- backpressure on r7, mid-dump writes to r9 and r3 ----
        start_a = 1'b1;
        ready_a = 1'b1;
        step();
        start_a = 1'b0;
        exp_n = 1; stall = 0; first7 = -1; last7 = -1; first8 = -1;
        wrote = 1'b0; prev_v = 1'b0; got_done = 1'b0;
        for (int t = 0; t < 200 && !got_done; t++) begin
            step();
            if (!wrote && rn_a == 5'd5) begin
                rf[9] = 32'hDEAD;
                rf[3] = 32'hBEEF;
                wrote = 1'b1;
            end
            if (valid_a && !prev_v) begin
                chk($sformatf("dumpB r%0d", exp_n), {27'd0, num_a, data_a},
                    {27'd0, 5'(exp_n), exp_b(exp_n)});
                if (exp_n == 7) first7 = t;
                if (exp_n == 8) first8 = t;
            end else if (valid_a) begin
                chk("dumpB hold", {27'd0, num_a, data_a}, {27'd0, 5'(exp_n), exp_b(exp_n)});
            end
            if (valid_a && exp_n == 7) last7 = t;
            if (valid_a && exp_n == 7 && stall < 5) begin
                ready_a = 1'b0;
                stall++;
            end else begin
                ready_a = 1'b1;
            end
            if (valid_a && ready_a) exp_n++;
            if (done_a) got_done = 1'b1;
            prev_v = valid_a;
        end
        chk("dumpB done seen", {63'd0, got_done}, 64'd1);
        chk("dumpB beat count", 64'(exp_n), 64'd32);
        chk("dumpB r7 stall", 64'(last7 - first7), 64'd5);
        chk("dumpB r8 spacing", 64'(first8 - last7), 64'd2);
        rf[3] = 32'd103;
        rf[9] = 32'd109;
        step();

        // ---- abort while r12 is pending with ready low ----
        start_a = 1'b1;
        ready_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_beat(12);
        ready_a = 1'b0;
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("abort outputs", {56'd0, valid_a, busy_a, done_a, rn_a}, 64'd0);
        early_done = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done_a || busy_a || valid_a) early_done++;
        end
        chk("abort stays idle", 64'(early_done), 64'd0);

        // ---- restart from r1, start mid-dump ignored, reset at r20 ----
        start_a = 1'b1;
        ready_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_beat(1);
        chk("restart r1", {27'd0, num_a, data_a}, {27'd0, 5'd1, 32'd101});
        wait_beat(15);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_beat(16);
        chk("ignored start r16", {27'd0, num_a, data_a}, {27'd0, 5'd16, 32'd116});
        wait_beat(20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset", {19'd0, rn_a, valid_a, num_a, data_a, busy_a, done_a}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("after reset idle", {19'd0, rn_a, valid_a, num_a, data_a, busy_a, done_a}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
